// File: rtl/lsu_mem_initiator.sv
// Load/store unit memory initiator: one request at a time, byte/half/word with lane steering and extension.
// Optional WAIT-state watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_initiator #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        ready,
   output logic        we,
   output logic [29:0] addr,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic        rresp,
   input  logic [31:0] rdata
);

   // state | meaning
   // IDLE  | waiting for a request, req_ready high
   // ISSUE | single-cycle memory strobe
   // WAIT  | load outstanding, waiting for rresp
   // RESP  | response held until rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("lsu_mem_initiator: TIMEOUT out of range 2..255");
   end

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]  cnt_q, cnt_d;
`endif

   logic        req_illegal, req_misaligned;
   logic [3:0]  strb_base;
   logic [31:0] wdata_rep;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      case (f3)
         3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
         3'b100:  extend = {24'h0, sh[7:0]};
         3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
         3'b101:  extend = {16'h0, sh[15:0]};
         default: extend = d;
      endcase
   endfunction

   always_comb begin
      req_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_funct3[2] && req_we);
      req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      case (req_funct3[1:0])
         2'b00:   begin strb_base = 4'b0001; wdata_rep = {4{req_wdata[7:0]}};  end
         2'b01:   begin strb_base = 4'b0011; wdata_rep = {2{req_wdata[15:0]}}; end
         default: begin strb_base = 4'b1111; wdata_rep = req_wdata;           end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      f3_d        = f3_q;
      off_d       = off_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_illegal || req_misaligned) begin
                  // rejected requests never touch the memory port
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else begin
                  state_d = S_ISSUE;
                  ready_d = 1'b1;
                  we_d    = req_we;
                  addr_d  = req_addr[31:2];
                  wdata_d = wdata_rep;
                  wstrb_d = strb_base << req_addr[1:0];
                  f3_d    = req_funct3;
                  off_d   = req_addr[1:0];
               end
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
            end else begin
               state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
               cnt_d   = 8'h0;
`endif
            end
         end
         S_WAIT: begin
            // rresp wins over a coincident timeout
            if (rresp) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = extend(f3_q, off_q, rdata);
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 30'h0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         f3_q        <= 3'h0;
         off_q       <= 2'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= 8'h0;
`endif
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign ready     = ready_q;
   assign we        = we_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed vector table, reset/timeout sequences, random traffic vs. model.
module tb_lsu_mem_initiator;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        resetb;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ready, we;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        rresp;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_bad = 0;

   lsu_mem_initiator #(.TIMEOUT(TO)) dut (
      .clk(clk), .resetb(resetb),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ready(ready), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rresp(rresp), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference behaviour from the access-size rules, not from any state machine.
   function automatic void model(input logic m_we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] mem,
                                 output logic err, output logic [31:0] rd,
                                 output logic [3:0] ws, output logic [31:0] wr);
      int nb, off;
      logic legal;
      logic [31:0] v, mask;
      off   = int'(a % 4);
      nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!m_we && (f3 == 3'd4 || f3 == 3'd5));
      err   = !legal || (off % nb != 0);
      ws    = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) wr[8*i +: 8] = wd[8*(i % nb) +: 8];
      rd = 32'h0;
      if (!err && !m_we) begin
         v = mem >> (8 * off);
         if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*nb-1]) v = v | ~mask;
         end
         rd = v;
      end
   endfunction

   // Starts and ends on a falling edge with the DUT idle.
   task automatic txn(input string tag, input logic t_we, input logic [2:0] t_f3,
                      input logic [31:0] t_addr, input logic [31:0] t_wdata, input logic [31:0] t_mem,
                      input int rdelay, input int hold,
                      input logic e_err, input logic [31:0] e_rd, input logic [3:0] e_ws,
                      input logic [31:0] e_wr, input int e_lat, input bit e_acc);
      int k, rdy_k, rdy_cnt;
      bit got;
      logic c_we;
      logic [29:0] c_addr;
      logic [31:0] c_wdata;
      logic [3:0] c_wstrb;
      check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = t_we; req_funct3 = t_f3; req_addr = t_addr; req_wdata = t_wdata;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      k = 1; rdy_k = -1; rdy_cnt = 0; got = 0;
      c_we = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
      while (k < 100) begin
         if (ready) begin
            rdy_cnt++; rdy_k = k;
            c_we = we; c_addr = addr; c_wdata = wdata; c_wstrb = wstrb;
         end
         if (rsp_valid) begin got = 1; break; end
         rresp = 1'b0; rdata = $urandom;
         if (rdy_k == k) begin
            rresp = 1'b1; rdata = 32'hDEADBEEF;
         end else if (rdy_k > 0 && k == rdy_k + rdelay) begin
            rresp = 1'b1; rdata = t_mem;
         end
         @(posedge clk); @(negedge clk); k++;
      end
      rresp = 1'b0;
      check({tag, "/rsp_seen"}, 32'(got), 32'd1);
      check({tag, "/latency"}, 32'(k), 32'(e_lat));
      check({tag, "/rsp_err"}, 32'(rsp_err), 32'(e_err));
      check({tag, "/rsp_rdata"}, rsp_rdata, e_rd);
      check({tag, "/ready_pulses"}, 32'(rdy_cnt), e_acc ? 32'd1 : 32'd0);
      if (e_acc) begin
         check({tag, "/we"}, 32'(c_we), 32'(t_we));
         check({tag, "/addr"}, 32'(c_addr), 32'(t_addr[31:2]));
         if (t_we) begin
            check({tag, "/wstrb"}, 32'(c_wstrb), 32'(e_ws));
            check({tag, "/wdata"}, c_wdata, e_wr);
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "/hold_rdata"}, rsp_rdata, e_rd);
         check({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "/idle_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "/idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      string       tag;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd, mem;
      int          rdelay, hold;
      logic        err;
      logic [31:0] rd;
      logic [3:0]  ws;
      logic [31:0] wr;
      int          lat;
      bit          acc;
   } vec_t;

   task automatic check_reset_outputs(input string tag);
      check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "/rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "/rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "/ready"}, 32'(ready), 32'd0);
      check({tag, "/we"}, 32'(we), 32'd0);
      check({tag, "/addr"}, 32'(addr), 32'd0);
      check({tag, "/wdata"}, wdata, 32'd0);
      check({tag, "/wstrb"}, 32'(wstrb), 32'd0);
   endtask

   initial begin
      vec_t vecs[$];
      logic r_we, m_err;
      logic [2:0] r_f3;
      logic [31:0] r_a, r_wd, r_mem, m_rd, m_wr;
      logic [3:0] m_ws;
      int r_dly, r_hold, lat;
      bit to_hit;

      vecs.push_back('{"SB_103",   1'b1, 3'b000, 32'h103, 32'hA5,       32'h0,        1, 0, 1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5, 2, 1'b1});
      vecs.push_back('{"LH_202",   1'b0, 3'b001, 32'h202, 32'h0,        32'h80011234, 1, 0, 1'b0, 32'hFFFF8001, 4'h0,    32'h0,        3, 1'b1});
      vecs.push_back('{"LHU_202",  1'b0, 3'b101, 32'h202, 32'h0,        32'h80011234, 1, 0, 1'b0, 32'h00008001, 4'h0,    32'h0,        3, 1'b1});
      vecs.push_back('{"LW_mis",   1'b0, 3'b010, 32'h006, 32'h0,        32'h12345678, 1, 0, 1'b1, 32'h0,        4'h0,    32'h0,        1, 1'b0});
      vecs.push_back('{"F3_011",   1'b0, 3'b011, 32'h000, 32'h0,        32'h12345678, 1, 0, 1'b1, 32'h0,        4'h0,    32'h0,        1, 1'b0});
      vecs.push_back('{"SW_hold",  1'b1, 3'b010, 32'h010, 32'h12345678, 32'h0,        1, 5, 1'b0, 32'h0,        4'b1111, 32'h12345678, 2, 1'b1});
      vecs.push_back('{"LB_hold",  1'b0, 3'b000, 32'h003, 32'h0,        32'h80000000, 3, 5, 1'b0, 32'hFFFFFF80, 4'h0,    32'h0,        5, 1'b1});
      vecs.push_back('{"SH_002",   1'b1, 3'b001, 32'h002, 32'hBEEF1234, 32'h0,        1, 0, 1'b0, 32'h0,        4'b1100, 32'h12341234, 2, 1'b1});
      vecs.push_back('{"LBU_001",  1'b0, 3'b100, 32'h001, 32'h0,        32'h0000FF00, 2, 0, 1'b0, 32'h000000FF, 4'h0,    32'h0,        4, 1'b1});
      vecs.push_back('{"SBU_ill",  1'b1, 3'b100, 32'h000, 32'h11,       32'h0,        1, 0, 1'b1, 32'h0,        4'h0,    32'h0,        1, 1'b0});
      vecs.push_back('{"SH_mis",   1'b1, 3'b001, 32'h001, 32'h11,       32'h0,        1, 0, 1'b1, 32'h0,        4'h0,    32'h0,        1, 1'b0});
      vecs.push_back('{"LW_008",   1'b0, 3'b010, 32'h008, 32'h0,        32'hCAFEF00D, 1, 0, 1'b0, 32'hCAFEF00D, 4'h0,    32'h0,        3, 1'b1});
      vecs.push_back('{"F3_110",   1'b0, 3'b110, 32'h004, 32'h0,        32'h0,        1, 0, 1'b1, 32'h0,        4'h0,    32'h0,        1, 1'b0});

      resetb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; rresp = 1'b0; rdata = '0;
      #1 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk); resetb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rresp = 1'b1; rdata = $urandom;
         @(posedge clk); @(negedge clk);
         check("post_reset_no_strobe", 32'(ready), 32'd0);
         check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      end
      rresp = 1'b0;

      foreach (vecs[i])
         txn(vecs[i].tag, vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].mem,
             vecs[i].rdelay, vecs[i].hold, vecs[i].err, vecs[i].rd, vecs[i].ws, vecs[i].wr,
             vecs[i].lat, vecs[i].acc);

`ifdef LSU_TIMEOUT_EN
      txn("timeout", 1'b0, 3'b010, 32'h20, 32'h0, 32'h55AA55AA, 1000, 0,
          1'b1, 32'h0, 4'h0, 32'h0, 2 + TO, 1'b1);
      txn("rresp_at_limit", 1'b0, 3'b010, 32'h20, 32'h0, 32'h55AA55AA, TO, 0,
          1'b0, 32'h55AA55AA, 4'h0, 32'h0, 2 + TO, 1'b1);
`endif

      // Reset pulse while a load sits in WAIT; a stale rresp afterwards must be ignored.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h9ABCDEF0;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      #2 resetb = 1'b0;
      #1 check_reset_outputs("mid_reset");
      @(negedge clk); resetb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rresp = 1'b1; rdata = 32'h11111111;
         @(posedge clk); @(negedge clk);
         check("late_rresp_no_rsp", 32'(rsp_valid), 32'd0);
         check("late_rresp_no_strobe", 32'(ready), 32'd0);
      end
      rresp = 1'b0;
      txn("LW_after_reset", 1'b0, 3'b010, 32'h44, 32'h0, 32'h5A5A5A5A, 1, 0,
          1'b0, 32'h5A5A5A5A, 4'h0, 32'h0, 3, 1'b1);

      for (int n = 0; n < 150; n++) begin
         r_we  = 1'($urandom);
         r_f3  = 3'($urandom_range(0, 7));
         r_a   = $urandom;
         if ($urandom_range(0, 1) == 0) r_a[1:0] = 2'b00;
         r_wd  = $urandom;
         r_mem = $urandom;
         r_hold = $urandom_range(0, 2);
`ifdef LSU_TIMEOUT_EN
         r_dly = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 3) : $urandom_range(1, 4);
`else
         r_dly = $urandom_range(1, 4);
`endif
         model(r_we, r_f3, r_a, r_wd, r_mem, m_err, m_rd, m_ws, m_wr);
         to_hit = !m_err && !r_we && (r_dly > TO);
         if (m_err)      lat = 1;
         else if (r_we)  lat = 2;
         else if (to_hit) lat = 2 + TO;
         else            lat = 2 + r_dly;
         txn($sformatf("rnd%0d", n), r_we, r_f3, r_a, r_wd, r_mem, r_dly, r_hold,
             m_err || to_hit, to_hit ? 32'h0 : m_rd, m_ws, m_wr, lat, !m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
